// File: rtl/board_lock_ctl_if.sv
// Lock handshake, piece squares and display read port between the piece controller and the playfield.
interface board_lock_ctl_if;
  logic        lock_en;
  logic [3:0]  sq_1_col;
  logic [3:0]  sq_2_col;
  logic [3:0]  sq_3_col;
  logic [3:0]  sq_4_col;
  logic [4:0]  sq_1_row;
  logic [4:0]  sq_2_row;
  logic [4:0]  sq_3_row;
  logic [4:0]  sq_4_row;
  logic [4:0]  block;
  logic [3:0]  rd_col;
  logic [4:0]  rd_row;
  logic [2:0]  rd_cell;
  logic        busy;
  logic        done;
  logic [2:0]  lines;
  logic [15:0] total_lines;
  logic        game_over;
  logic        oob_err;

  modport master (
    output lock_en, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
    output sq_1_row, sq_2_row, sq_3_row, sq_4_row, block, rd_col, rd_row,
    input  rd_cell, busy, done, lines, total_lines, game_over, oob_err
  );

  modport slave (
    input  lock_en, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
    input  sq_1_row, sq_2_row, sq_3_row, sq_4_row, block, rd_col, rd_row,
    output rd_cell, busy, done, lines, total_lines, game_over, oob_err
  );
endinterface

// File: rtl/board_lock_ctl.sv
// Playfield store: writes a locked piece's four squares, removes full rows bottom-up,
// counts cleared lines and exposes a registered cell read port for the display.
module board_lock_ctl #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic            pclk,
  input  logic            rst_n,
  board_lock_ctl_if.slave bus
);
  localparam logic [3:0] COL_LIM  = 4'(COLS);
  localparam logic [4:0] ROW_LIM  = 5'(ROWS);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]  cells [ROWS][COLS];
  logic [3:0]  lat_col [4];
  logic [4:0]  lat_row [4];
  logic [2:0]  colour;
  logic [2:0]  colour_in;
  logic [1:0]  idx;
  logic [4:0]  scan_row;
  logic [4:0]  shift_row;
  logic [4:0]  src_row;
  logic [2:0]  cleared;
  logic [2:0]  lines_q;
  logic [2:0]  rd_cell_q;
  logic [15:0] total_q;
  logic        top_hit;
  logic        game_over_q;
  logic        oob_q;
  logic        accept;
  logic        row_full;
  logic        wr_ok;
  logic [3:0]  wr_col;
  logic [4:0]  wr_row;
  logic        unused_block_bit;

  // Only the piece index bits and the valid-code flag select a colour.
  assign unused_block_bit = bus.block[3];
  assign colour_in = (!bus.block[4] || bus.block[2:0] == 3'd7) ? 3'd7 : bus.block[2:0] + 3'd1;

  assign accept  = (state == IDLE) && bus.lock_en && !game_over_q;
  assign wr_col  = lat_col[idx];
  assign wr_row  = lat_row[idx];
  assign wr_ok   = (wr_row < ROW_LIM) && (wr_col < COL_LIM);
  assign src_row = shift_row - 5'd1;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cells[scan_row][c] == 3'd0) row_full = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WRITE;
      WRITE:   if (idx == 2'd3) state_nxt = SCAN;
      SCAN: begin
        if (row_full)               state_nxt = SHIFT;
        else if (scan_row == 5'd0)  state_nxt = DONE;
      end
      SHIFT:   if (shift_row == 5'd0) state_nxt = SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      idx         <= '0;
      scan_row    <= '0;
      shift_row   <= '0;
      cleared     <= '0;
      colour      <= '0;
      top_hit     <= 1'b0;
      lines_q     <= '0;
      total_q     <= '0;
      game_over_q <= 1'b0;
      oob_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lat_col[i] <= '0;
        lat_row[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_col[0] <= bus.sq_1_col;
            lat_col[1] <= bus.sq_2_col;
            lat_col[2] <= bus.sq_3_col;
            lat_col[3] <= bus.sq_4_col;
            lat_row[0] <= bus.sq_1_row;
            lat_row[1] <= bus.sq_2_row;
            lat_row[2] <= bus.sq_3_row;
            lat_row[3] <= bus.sq_4_row;
            colour     <= colour_in;
            idx        <= '0;
            top_hit    <= (bus.sq_1_row == 5'd0) || (bus.sq_2_row == 5'd0) ||
                          (bus.sq_3_row == 5'd0) || (bus.sq_4_row == 5'd0);
          end
        end
        WRITE: begin
          if (!wr_ok) oob_q <= 1'b1;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            scan_row <= ROW_LAST;
            cleared  <= '0;
          end
        end
        SCAN: begin
          // Results are committed on the way into DONE so they are valid alongside done.
          if (row_full) begin
            shift_row <= scan_row;
          end else if (scan_row == 5'd0) begin
            lines_q <= cleared;
            total_q <= total_q + 16'(cleared);
            if (top_hit) game_over_q <= 1'b1;
          end else begin
            scan_row <= scan_row - 5'd1;
          end
        end
        SHIFT: begin
          if (shift_row != 5'd0) shift_row <= src_row;
          else                   cleared   <= cleared + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) cells[r][c] <= '0;
      end
    end else if (state == WRITE && wr_ok) begin
      cells[wr_row][wr_col] <= colour;
    end else if (state == SHIFT) begin
      // scan_row is left untouched, so the row dropped into it is checked again.
      for (int c = 0; c < COLS; c++) begin
        if (shift_row == 5'd0) cells[0][c]         <= '0;
        else                   cells[shift_row][c] <= cells[src_row][c];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n)                                          rd_cell_q <= '0;
    else if (bus.rd_row < ROW_LIM && bus.rd_col < COL_LIM) rd_cell_q <= cells[bus.rd_row][bus.rd_col];
    else                                                 rd_cell_q <= '0;
  end

  assign bus.rd_cell     = rd_cell_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.lines       = lines_q;
  assign bus.total_lines = total_q;
  assign bus.game_over   = game_over_q;
  assign bus.oob_err     = oob_q;
endmodule
